alu_operand_stage: RTL and testbench

- Operand-supply stage directly upstream of the 16-bit ALU.
- Holds the architectural registers mary (accumulator), shelley (secondary) and sp (stack pointer).
- Latches the current instruction and generates the three immediate operands the ALU consumes: zext_imm, sext_imm and sext_ls_imm.
- Accepts write-back from the ALU result or from memory data, and keeps a sticky overflow flag built from the ALU Overflow output.

---
 rtl/alu_operand_stage_pkg.sv | 52 +++++
 rtl/alu_operand_stage_imm_gen.sv | 33 +++
 rtl/alu_operand_stage.sv | 119 +++++++++++
 tb/tb_alu_operand_stage.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_operand_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_stage_pkg
// Description : Shared encodings for the ALU operand-supply stage and the
//               ALU datapath it feeds: write-back source select, operand-B
//               select, ALU operation codes and stack-pointer defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_operand_stage_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned IMM_W  = 8;

  // Write-back source select: the value written into mary/shelley/sp.
  localparam logic WB_ALU = 1'b0;
  localparam logic WB_MEM = 1'b1;

  // Reset value and push/pop byte step of the stack pointer.
  localparam logic [DATA_W-1:0] SP_INIT_DEFAULT = 16'h7FFE;
  localparam logic [DATA_W-1:0] SP_STEP_DEFAULT = 16'd2;

  // Operand-B select consumed by the downstream ALU mux.
  typedef enum logic [1:0] {
    SRCB_SHELLEY = 2'b00,
    SRCB_ZEXT    = 2'b01,
    SRCB_SEXT    = 2'b10,
    SRCB_SEXT_LS = 2'b11
  } srcb_sel_e;

  // ALU operation codes consumed by the downstream ALU.
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b011,
    ALU_SLT = 3'b100,
    ALU_SGT = 3'b101,
    ALU_SEQ = 3'b110
  } alu_op_e;

  // Sign-extend an 8-bit immediate field to the datapath width.
  function automatic logic [DATA_W-1:0] sext8(input logic [IMM_W-1:0] v);
    return {{(DATA_W-IMM_W){v[IMM_W-1]}}, v};
  endfunction

  // Zero-extend an 8-bit immediate field to the datapath width.
  function automatic logic [DATA_W-1:0] zext8(input logic [IMM_W-1:0] v);
    return {{(DATA_W-IMM_W){1'b0}}, v};
  endfunction

endpackage : alu_operand_stage_pkg
`default_nettype wire

// File: rtl/alu_operand_stage_imm_gen.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_stage_imm_gen
// Description : Combinational immediate generator. Derives the zero-extended,
//               sign-extended and sign-extended-shifted-by-two immediates from
//               the low byte of the latched instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_stage_imm_gen
  import alu_operand_stage_pkg::*;
(
  input  logic [15:0] instr,
  output logic [15:0] zext_imm,
  output logic [15:0] sext_imm,
  output logic [15:0] sext_ls_imm
);

  logic [15:0] sext_w;

  // Extend the low byte; the shifted form drops the top two bits (mod 2^16).
  always_comb begin
    sext_w      = sext8(instr[7:0]);
    zext_imm    = zext8(instr[7:0]);
    sext_imm    = sext_w;
    sext_ls_imm = {sext_w[13:0], 2'b00};
  end

  // Upper instruction bits carry opcode/register fields used elsewhere.
  logic unused_hi;
  assign unused_hi = ^instr[15:8];

endmodule : alu_operand_stage_imm_gen
`default_nettype wire

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_stage
// Description : Operand-supply stage upstream of the 16-bit ALU. Holds the
//               instruction register and the mary/shelley/sp architectural
//               registers, selects the write-back source, and keeps a sticky
//               overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter logic [15:0] SP_INIT = SP_INIT_DEFAULT,
  parameter logic [15:0] SP_STEP = SP_STEP_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        IRWrite,
  input  logic [15:0] instr_in,
  input  logic [15:0] alu_out,
  input  logic [15:0] mem_data,
  input  logic        WbSrc,
  input  logic        MaryWrite,
  input  logic        ShelleyWrite,
  input  logic        SpWrite,
  input  logic        SpPush,
  input  logic        SpPop,
  input  logic        Overflow,
  input  logic        FlagWrite,
  input  logic        FlagClear,
  output logic [15:0] instr,
  output logic [15:0] mary,
  output logic [15:0] shelley,
  output logic [15:0] sp,
  output logic [15:0] zext_imm,
  output logic [15:0] sext_imm,
  output logic [15:0] sext_ls_imm,
  output logic        ovf_flag
);

  logic [15:0] wb;
  logic [15:0] instr_d,   instr_q;
  logic [15:0] mary_d,    mary_q;
  logic [15:0] shelley_d, shelley_q;
  logic [15:0] sp_d,      sp_q;
  logic        ovf_d,     ovf_q;

  // Write-back source mux shared by all three architectural registers.
  always_comb begin
    wb = (WbSrc == WB_MEM) ? mem_data : alu_out;
  end

  // Next-state logic; the new instruction never influences same-cycle writes.
  always_comb begin
    instr_d   = instr_q;
    mary_d    = mary_q;
    shelley_d = shelley_q;
    sp_d      = sp_q;
    ovf_d     = ovf_q;

    if (IRWrite) begin
      instr_d = instr_in;
    end
    if (MaryWrite) begin
      mary_d = wb;
    end
    if (ShelleyWrite) begin
      shelley_d = wb;
    end

    // Explicit write beats stack adjust; simultaneous push and pop cancel.
    if (SpWrite) begin
      sp_d = wb;
    end else if (SpPush && !SpPop) begin
      sp_d = sp_q - SP_STEP;
    end else if (SpPop && !SpPush) begin
      sp_d = sp_q + SP_STEP;
    end

    // Clear dominates; otherwise the flag only ever accumulates.
    if (FlagClear) begin
      ovf_d = 1'b0;
    end else if (FlagWrite) begin
      ovf_d = ovf_q | Overflow;
    end
  end

  // State registers; reset overrides every strobe on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      instr_q   <= 16'h0000;
      mary_q    <= 16'h0000;
      shelley_q <= 16'h0000;
      sp_q      <= SP_INIT;
      ovf_q     <= 1'b0;
    end else begin
      instr_q   <= instr_d;
      mary_q    <= mary_d;
      shelley_q <= shelley_d;
      sp_q      <= sp_d;
      ovf_q     <= ovf_d;
    end
  end

  assign instr    = instr_q;
  assign mary     = mary_q;
  assign shelley  = shelley_q;
  assign sp       = sp_q;
  assign ovf_flag = ovf_q;

  alu_operand_stage_imm_gen u_imm_gen (
    .instr       (instr_q),
    .zext_imm    (zext_imm),
    .sext_imm    (sext_imm),
    .sext_ls_imm (sext_ls_imm)
  );

endmodule : alu_operand_stage
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_operand_stage
// Description : Directed self-checking bench for alu_operand_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_operand_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        IRWrite;
  logic [15:0] instr_in;
  logic [15:0] alu_out;
  logic [15:0] mem_data;
  logic        WbSrc;
  logic        MaryWrite;
  logic        ShelleyWrite;
  logic        SpWrite;
  logic        SpPush;
  logic        SpPop;
  logic        Overflow;
  logic        FlagWrite;
  logic        FlagClear;
  logic [15:0] instr;
  logic [15:0] mary;
  logic [15:0] shelley;
  logic [15:0] sp;
  logic [15:0] zext_imm;
  logic [15:0] sext_imm;
  logic [15:0] sext_ls_imm;
  logic        ovf_flag;

  int n_checks = 0;
  int n_fail   = 0;

  alu_operand_stage dut (
    .clock        (clock),
    .reset        (reset),
    .IRWrite      (IRWrite),
    .instr_in     (instr_in),
    .alu_out      (alu_out),
    .mem_data     (mem_data),
    .WbSrc        (WbSrc),
    .MaryWrite    (MaryWrite),
    .ShelleyWrite (ShelleyWrite),
    .SpWrite      (SpWrite),
    .SpPush       (SpPush),
    .SpPop        (SpPop),
    .Overflow     (Overflow),
    .FlagWrite    (FlagWrite),
    .FlagClear    (FlagClear),
    .instr        (instr),
    .mary         (mary),
    .shelley      (shelley),
    .sp           (sp),
    .zext_imm     (zext_imm),
    .sext_imm     (sext_imm),
    .sext_ls_imm  (sext_ls_imm),
    .ovf_flag     (ovf_flag)
  );

  always #5 clock = ~clock;

  // Advance one edge; outputs are sampled and inputs changed 1 time unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    reset        = 1'b0;
    IRWrite      = 1'b0;
    instr_in     = 16'h0000;
    alu_out      = 16'h0000;
    mem_data     = 16'h0000;
    WbSrc        = 1'b0;
    MaryWrite    = 1'b0;
    ShelleyWrite = 1'b0;
    SpWrite      = 1'b0;
    SpPush       = 1'b0;
    SpPop        = 1'b0;
    Overflow     = 1'b0;
    FlagWrite    = 1'b0;
    FlagClear    = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1; IRWrite = 1'b1; instr_in = 16'hABCD; alu_out = 16'h1234;
    MaryWrite = 1'b1; ShelleyWrite = 1'b1; SpWrite = 1'b1; SpPush = 1'b1;
    Overflow = 1'b1; FlagWrite = 1'b1;
    tick(); tick();
    n_checks++; if (mary !== 16'h0000) begin n_fail++; $display("FAIL reset_mary: got %h expected %h", mary, 16'h0000); end
    n_checks++; if (shelley !== 16'h0000) begin n_fail++; $display("FAIL reset_shelley: got %h expected %h", shelley, 16'h0000); end
    n_checks++; if (sp !== 16'h7FFE) begin n_fail++; $display("FAIL reset_sp: got %h expected %h", sp, 16'h7FFE); end
    n_checks++; if (instr !== 16'h0000) begin n_fail++; $display("FAIL reset_instr: got %h expected %h", instr, 16'h0000); end
    n_checks++; if (ovf_flag !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected %b", ovf_flag, 1'b0); end
    n_checks++; if (sext_ls_imm !== 16'h0000) begin n_fail++; $display("FAIL reset_imm: got %h expected %h", sext_ls_imm, 16'h0000); end
    idle();
  endtask

  task automatic test_immediates();
    idle();
    IRWrite = 1'b1; instr_in = 16'h0022;
    tick();
    idle();
    n_checks++; if (instr !== 16'h0022) begin n_fail++; $display("FAIL imm_pos_instr: got %h expected %h", instr, 16'h0022); end
    n_checks++; if (zext_imm !== 16'd34) begin n_fail++; $display("FAIL imm_pos_zext: got %h expected %h", zext_imm, 16'd34); end
    n_checks++; if (sext_imm !== 16'd34) begin n_fail++; $display("FAIL imm_pos_sext: got %h expected %h", sext_imm, 16'd34); end
    n_checks++; if (sext_ls_imm !== 16'd136) begin n_fail++; $display("FAIL imm_pos_sls: got %h expected %h", sext_ls_imm, 16'd136); end
    IRWrite = 1'b1; instr_in = 16'h00F0;
    tick();
    idle();
    n_checks++; if (zext_imm !== 16'd240) begin n_fail++; $display("FAIL imm_neg_zext: got %h expected %h", zext_imm, 16'd240); end
    n_checks++; if (sext_imm !== 16'hFFF0) begin n_fail++; $display("FAIL imm_neg_sext: got %h expected %h", sext_imm, 16'hFFF0); end
    n_checks++; if (sext_ls_imm !== 16'hFFC0) begin n_fail++; $display("FAIL imm_neg_sls: got %h expected %h", sext_ls_imm, 16'hFFC0); end
    // Upper byte must not leak into the immediates; IRWrite low must hold.
    IRWrite = 1'b1; instr_in = 16'h5A81;
    tick();
    idle();
    instr_in = 16'h1111;
    tick();
    n_checks++; if (instr !== 16'h5A81) begin n_fail++; $display("FAIL imm_hold_instr: got %h expected %h", instr, 16'h5A81); end
    n_checks++; if (zext_imm !== 16'h0081) begin n_fail++; $display("FAIL imm_hi_zext: got %h expected %h", zext_imm, 16'h0081); end
    n_checks++; if (sext_imm !== 16'hFF81) begin n_fail++; $display("FAIL imm_hi_sext: got %h expected %h", sext_imm, 16'hFF81); end
    n_checks++; if (sext_ls_imm !== 16'hFE04) begin n_fail++; $display("FAIL imm_hi_sls: got %h expected %h", sext_ls_imm, 16'hFE04); end
  endtask

  task automatic test_writeback();
    idle();
    alu_out = 16'd57; mem_data = 16'd99; WbSrc = 1'b0; MaryWrite = 1'b1;
    tick();
    idle();
    n_checks++; if (mary !== 16'd57) begin n_fail++; $display("FAIL wb_alu_mary: got %h expected %h", mary, 16'd57); end
    n_checks++; if (shelley !== 16'd0) begin n_fail++; $display("FAIL wb_alu_shelley: got %h expected %h", shelley, 16'd0); end
    mem_data = 16'd75; alu_out = 16'd11; WbSrc = 1'b1; ShelleyWrite = 1'b1;
    tick();
    idle();
    n_checks++; if (shelley !== 16'd75) begin n_fail++; $display("FAIL wb_mem_shelley: got %h expected %h", shelley, 16'd75); end
    n_checks++; if (mary !== 16'd57) begin n_fail++; $display("FAIL wb_mem_mary_hold: got %h expected %h", mary, 16'd57); end
    // Both registers in one cycle, alongside a new instruction fetch.
    alu_out = 16'h0AAA; WbSrc = 1'b0; MaryWrite = 1'b1; ShelleyWrite = 1'b1;
    IRWrite = 1'b1; instr_in = 16'h00FF;
    tick();
    idle();
    n_checks++; if (mary !== 16'h0AAA) begin n_fail++; $display("FAIL wb_both_mary: got %h expected %h", mary, 16'h0AAA); end
    n_checks++; if (shelley !== 16'h0AAA) begin n_fail++; $display("FAIL wb_both_shelley: got %h expected %h", shelley, 16'h0AAA); end
    n_checks++; if (zext_imm !== 16'h00FF) begin n_fail++; $display("FAIL wb_both_zext: got %h expected %h", zext_imm, 16'h00FF); end
  endtask

  task automatic test_stack();
    idle();
    SpPush = 1'b1;
    tick();
    n_checks++; if (sp !== 16'h7FFC) begin n_fail++; $display("FAIL sp_push1: got %h expected %h", sp, 16'h7FFC); end
    tick();
    idle();
    n_checks++; if (sp !== 16'h7FFA) begin n_fail++; $display("FAIL sp_push2: got %h expected %h", sp, 16'h7FFA); end
    SpPop = 1'b1;
    tick();
    idle();
    n_checks++; if (sp !== 16'h7FFC) begin n_fail++; $display("FAIL sp_pop: got %h expected %h", sp, 16'h7FFC); end
    SpPush = 1'b1; SpPop = 1'b1;
    tick();
    idle();
    n_checks++; if (sp !== 16'h7FFC) begin n_fail++; $display("FAIL sp_push_pop_hold: got %h expected %h", sp, 16'h7FFC); end
    SpWrite = 1'b1; SpPush = 1'b1; alu_out = 16'h0000; WbSrc = 1'b0;
    tick();
    idle();
    n_checks++; if (sp !== 16'h0000) begin n_fail++; $display("FAIL sp_write_prio: got %h expected %h", sp, 16'h0000); end
    SpPush = 1'b1;
    tick();
    idle();
    n_checks++; if (sp !== 16'hFFFE) begin n_fail++; $display("FAIL sp_wrap_push: got %h expected %h", sp, 16'hFFFE); end
    SpPop = 1'b1;
    tick();
    idle();
    n_checks++; if (sp !== 16'h0000) begin n_fail++; $display("FAIL sp_wrap_pop: got %h expected %h", sp, 16'h0000); end
    SpWrite = 1'b1; WbSrc = 1'b1; mem_data = 16'h4242; alu_out = 16'h1313; SpPop = 1'b1;
    tick();
    idle();
    n_checks++; if (sp !== 16'h4242) begin n_fail++; $display("FAIL sp_write_mem: got %h expected %h", sp, 16'h4242); end
  endtask

  task automatic test_flag();
    idle();
    Overflow = 1'b1;
    tick();
    n_checks++; if (ovf_flag !== 1'b0) begin n_fail++; $display("FAIL flag_no_write: got %b expected %b", ovf_flag, 1'b0); end
    FlagWrite = 1'b1; Overflow = 1'b1;
    tick();
    idle();
    n_checks++; if (ovf_flag !== 1'b1) begin n_fail++; $display("FAIL flag_set: got %b expected %b", ovf_flag, 1'b1); end
    FlagWrite = 1'b1; Overflow = 1'b0;
    tick();
    idle();
    n_checks++; if (ovf_flag !== 1'b1) begin n_fail++; $display("FAIL flag_sticky: got %b expected %b", ovf_flag, 1'b1); end
    FlagWrite = 1'b1; FlagClear = 1'b1; Overflow = 1'b1;
    tick();
    idle();
    n_checks++; if (ovf_flag !== 1'b0) begin n_fail++; $display("FAIL flag_clear_prio: got %b expected %b", ovf_flag, 1'b0); end
  endtask

  task automatic test_mid_reset();
    idle();
    alu_out = 16'd91; MaryWrite = 1'b1;
    tick();
    idle();
    alu_out = 16'h7FF0; SpWrite = 1'b1;
    tick();
    idle();
    FlagWrite = 1'b1; Overflow = 1'b1; ShelleyWrite = 1'b1; alu_out = 16'h0101;
    IRWrite = 1'b1; instr_in = 16'h0033;
    tick();
    idle();
    n_checks++; if (mary !== 16'd91) begin n_fail++; $display("FAIL pre_reset_mary: got %h expected %h", mary, 16'd91); end
    n_checks++; if (sp !== 16'h7FF0) begin n_fail++; $display("FAIL pre_reset_sp: got %h expected %h", sp, 16'h7FF0); end
    reset = 1'b1; MaryWrite = 1'b1; SpPop = 1'b1; alu_out = 16'h5555;
    tick();
    idle();
    n_checks++; if (mary !== 16'h0000) begin n_fail++; $display("FAIL mid_reset_mary: got %h expected %h", mary, 16'h0000); end
    n_checks++; if (sp !== 16'h7FFE) begin n_fail++; $display("FAIL mid_reset_sp: got %h expected %h", sp, 16'h7FFE); end
    n_checks++; if (shelley !== 16'h0000) begin n_fail++; $display("FAIL mid_reset_shelley: got %h expected %h", shelley, 16'h0000); end
    n_checks++; if (ovf_flag !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ovf: got %b expected %b", ovf_flag, 1'b0); end
    n_checks++; if (zext_imm !== 16'h0000) begin n_fail++; $display("FAIL mid_reset_imm: got %h expected %h", zext_imm, 16'h0000); end
  endtask

  initial begin
    idle();
    test_reset();
    test_immediates();
    test_writeback();
    test_stack();
    test_flag();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_alu_operand_stage
`default_nettype wire
